aes_block_sequencer: RTL and testbench

Initiator-side sequencer for the AES crypto processor's START/DONE command interface. Accepts 128-bit blocks on a valid/ready input stream, drives one encrypt or decrypt command per block into the core, and captures the result. Presents the result on a valid/ready output stream, with a watchdog flag if the core fails to respond. Sits between the system datapath and the AES_Crypto_Processor instance; it performs in hardware the role the bench plays today.

---
 rtl/aes_seq_pkg.sv | 15 +
 rtl/aes_block_sequencer.sv | 145 ++++++++++++++
 tb/tb_aes_block_sequencer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES block sequencer.
package aes_seq_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } seq_state_e;

endpackage

// File: rtl/aes_block_sequencer.sv
// Drives one START/DONE command per input block into the AES core and
// presents the captured result (or a watchdog error) on a valid/ready output.
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [AES_BLOCK_W-1:0] KEY_IN,
  input  logic                   KEY_LOAD,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [AES_BLOCK_W-1:0] IN_DATA,
  input  logic                   IN_MODE,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [AES_BLOCK_W-1:0] OUT_DATA,
  output logic                   OUT_MODE,
  output logic                   OUT_ERR,
  output logic                   BUSY,
  output logic                   CORE_START,
  output logic                   CORE_ENCDEC,
  output logic [AES_BLOCK_W-1:0] CORE_KEY,
  output logic [AES_BLOCK_W-1:0] CORE_TEXTIN,
  input  logic                   CORE_DONE,
  input  logic [AES_BLOCK_W-1:0] CORE_TEXTOUT
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

  seq_state_e             state_q, state_d;
  logic [AES_BLOCK_W-1:0] key_q, key_d;
  logic [AES_BLOCK_W-1:0] data_q, data_d;
  logic                   mode_q, mode_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   done_q, done_d;
  logic                   out_valid_q, out_valid_d;
  logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
  logic                   out_mode_q, out_mode_d;
  logic                   out_err_q, out_err_d;

  logic                   in_ready;
  logic                   completion;
  logic [TIMER_W-1:0]     timer_inc;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    data_d      = data_q;
    mode_d      = mode_q;
    timer_d     = timer_q;
    done_d      = CORE_DONE;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mode_d  = out_mode_q;
    out_err_d   = out_err_q;
    in_ready    = 1'b0;
    // Only a fresh rising edge of DONE counts; a level left over from an
    // earlier command must not complete the current one.
    completion  = CORE_DONE & ~done_q;
    timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;

    if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        in_ready = ~out_valid_q | OUT_READY;
        if (KEY_LOAD) begin
          key_d = KEY_IN;
        end
        if (IN_VALID && in_ready) begin
          data_d  = IN_DATA;
          mode_d  = IN_MODE;
          state_d = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (completion) begin
          out_data_d  = CORE_TEXTOUT;
          out_mode_d  = mode_q;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TIMER_MAX) begin
            out_data_d  = '0;
            out_mode_d  = mode_q;
            out_err_d   = 1'b1;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      key_q       <= '0;
      data_q      <= '0;
      mode_q      <= MODE_ENC;
      timer_q     <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      timer_q     <= timer_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mode_q  <= out_mode_d;
      out_err_q   <= out_err_d;
    end
  end

  // RST gates the handshake and the command pulse so both drop in the reset cycle itself.
  assign IN_READY    = in_ready & ~RST;
  assign CORE_START  = (state_q == START) & ~RST;
  assign CORE_ENCDEC = (mode_q == MODE_DEC);
  assign CORE_KEY    = key_q;
  assign CORE_TEXTIN = data_q;
  assign BUSY        = (state_q != IDLE);
  assign OUT_VALID   = out_valid_q;
  assign OUT_DATA    = out_data_q;
  assign OUT_MODE    = out_mode_q;
  assign OUT_ERR     = out_err_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Randomized self-checking bench for aes_block_sequencer with a behavioural
// AES core stand-in and a key/result reference model.
module tb_aes_block_sequencer;

  localparam int TMO = 16;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] KEY_IN;
  logic         KEY_LOAD;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN_DATA;
  logic         IN_MODE;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_DATA;
  logic         OUT_MODE;
  logic         OUT_ERR;
  logic         BUSY;
  logic         CORE_START;
  logic         CORE_ENCDEC;
  logic [127:0] CORE_KEY;
  logic [127:0] CORE_TEXTIN;
  logic         CORE_DONE = 1'b0;
  logic [127:0] CORE_TEXTOUT = '0;

  int checks = 0;
  int errors = 0;

  int           core_latency   = 4;
  bit           core_dead      = 1'b0;
  bit           core_keep_done = 1'b0;
  logic [127:0] cm_key, cm_data;
  logic         cm_mode;
  int           cm_cnt  = 0;
  bit           cm_busy = 1'b0;

  logic [127:0] model_key;

  always #5 CLK = ~CLK;

  aes_block_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST), .KEY_IN(KEY_IN), .KEY_LOAD(KEY_LOAD),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_MODE(IN_MODE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_MODE(OUT_MODE), .OUT_ERR(OUT_ERR), .BUSY(BUSY),
    .CORE_START(CORE_START), .CORE_ENCDEC(CORE_ENCDEC), .CORE_KEY(CORE_KEY),
    .CORE_TEXTIN(CORE_TEXTIN), .CORE_DONE(CORE_DONE), .CORE_TEXTOUT(CORE_TEXTOUT)
  );

  // Known FIPS-197 / SP800-38A vectors; any other input gets a keyed scramble.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] d,
                                           input logic m);
    if (k == KEY1 && d == PT1 && !m) return CT1;
    if (k == KEY1 && d == CT1 && m) return PT1;
    if (k == KEY2 && d == PT2 && !m) return CT2;
    return d ^ {k[63:0], k[127:64]} ^ {128{m}} ^ 128'h5a;
  endfunction

  // Core stand-in: DONE rises core_latency cycles after START and stays high.
  always @(posedge CLK) begin
    if (RST) begin
      CORE_DONE <= 1'b0;
      cm_busy   <= 1'b0;
      cm_cnt    <= 0;
    end else if (CORE_START) begin
      cm_key  <= CORE_KEY;
      cm_data <= CORE_TEXTIN;
      cm_mode <= CORE_ENCDEC;
      cm_cnt  <= core_latency;
      cm_busy <= 1'b1;
      if (!core_keep_done) CORE_DONE <= 1'b0;
    end else if (cm_busy) begin
      if (cm_cnt == 2) CORE_DONE <= 1'b0;
      if (cm_cnt == 1) begin
        cm_busy <= 1'b0;
        if (!core_dead) begin
          CORE_DONE    <= 1'b1;
          CORE_TEXTOUT <= aes_ref(cm_key, cm_data, cm_mode);
        end
      end
      cm_cnt <= cm_cnt - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one block; returns at the negedge of the cycle after the handshake.
  task automatic applyStimulus(input logic [127:0] data, input logic mode, input logic load_key,
                               input logic [127:0] key, input string tag);
    int guard = 0;
    IN_DATA  = data;
    IN_MODE  = mode;
    IN_VALID = 1'b1;
    KEY_LOAD = load_key;
    KEY_IN   = key;
    #1;
    while (!IN_READY && guard < 50) begin
      @(negedge CLK);
      #1;
      guard++;
    end
    checkOutput({tag, "_accept"}, 128'(IN_READY), 128'(1));
    @(posedge CLK);
    if (load_key) model_key = key;
    @(negedge CLK);
    checkOutput({tag, "_start"}, 128'(CORE_START), 128'(1));
    checkOutput({tag, "_textin"}, CORE_TEXTIN, data);
    checkOutput({tag, "_encdec"}, 128'(CORE_ENCDEC), 128'(mode));
    checkOutput({tag, "_key"}, CORE_KEY, model_key);
    IN_VALID  = 1'b0;
    KEY_LOAD  = 1'b0;
    OUT_READY = 1'b0;
  endtask

  // Counts cycles (START cycle = 1) until OUT_VALID; optionally pokes KEY_LOAD mid-WAIT.
  task automatic wait_valid(input bit poke, input string tag, output int n);
    bit extra_start = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 60) begin
      @(negedge CLK);
      n++;
      if (CORE_START) extra_start = 1'b1;
      if (poke && n == 3) begin
        KEY_LOAD = 1'b1;
        KEY_IN   = rand128();
      end else if (poke && n == 4) begin
        KEY_LOAD = 1'b0;
        checkOutput({tag, "_key_ignored"}, CORE_KEY, model_key);
      end
    end
    checkOutput({tag, "_valid"}, 128'(OUT_VALID), 128'(1));
    checkOutput({tag, "_start_1cyc"}, 128'(extra_start), 128'(0));
  endtask

  task automatic drain(input string tag);
    OUT_READY = 1'b1;
    @(negedge CLK);
    checkOutput({tag, "_drain"}, 128'(OUT_VALID), 128'(0));
    OUT_READY = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] data, input logic mode, input logic load_key,
                           input logic [127:0] key, input int lat, input bit dead,
                           input bit poke, input string tag);
    int n;
    int hold;
    logic [127:0] exp;
    core_latency = lat;
    core_dead    = dead;
    applyStimulus(data, mode, load_key, key, tag);
    exp = dead ? 128'(0) : aes_ref(model_key, data, mode);
    wait_valid(poke, tag, n);
    checkOutput({tag, "_lat"}, 128'(n), dead ? 128'(TMO + 2) : 128'(lat + 3));
    checkOutput({tag, "_err"}, 128'(OUT_ERR), 128'(dead));
    checkOutput({tag, "_data"}, OUT_DATA, exp);
    if (!dead) checkOutput({tag, "_mode"}, 128'(OUT_MODE), 128'(mode));
    checkOutput({tag, "_idle"}, 128'(BUSY), 128'(0));
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge CLK);
      checkOutput({tag, "_hold"}, OUT_DATA, exp);
    end
    drain(tag);
    core_dead = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    logic [127:0] a, b, exp_a;

    RST = 1'b1; KEY_IN = '0; KEY_LOAD = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
    IN_MODE = 1'b0; OUT_READY = 1'b0; model_key = '0;
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("rst_in_ready", 128'(IN_READY), 128'(0));
    checkOutput("rst_busy", 128'(BUSY), 128'(0));
    checkOutput("rst_out_valid", 128'(OUT_VALID), 128'(0));
    checkOutput("rst_out_data", OUT_DATA, 128'(0));
    checkOutput("rst_out_err", 128'(OUT_ERR), 128'(0));
    checkOutput("rst_core_start", 128'(CORE_START), 128'(0));
    checkOutput("rst_core_key", CORE_KEY, 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("ready_after_reset", 128'(IN_READY), 128'(1));

    run_block(PT1, 1'b0, 1'b1, KEY1, 5, 1'b0, 1'b0, "enc_v1");
    run_block(CT1, 1'b1, 1'b0, '0, 4, 1'b0, 1'b0, "dec_v1");

    // Backpressure: first result held while a second block waits.
    core_latency = 4;
    a = rand128();
    b = rand128();
    applyStimulus(a, 1'b0, 1'b0, '0, "bp_a");
    exp_a = aes_ref(model_key, a, 1'b0);
    wait_valid(1'b0, "bp_a", n);
    checkOutput("bp_a_lat", 128'(n), 128'(7));
    checkOutput("bp_a_data", OUT_DATA, exp_a);
    IN_DATA = b; IN_MODE = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      checkOutput("bp_in_ready_low", 128'(IN_READY), 128'(0));
      checkOutput("bp_valid_hold", 128'(OUT_VALID), 128'(1));
      checkOutput("bp_data_hold", OUT_DATA, exp_a);
    end
    @(negedge CLK);
    OUT_READY = 1'b1;
    #1;
    checkOutput("bp_ready_same_cycle", 128'(IN_READY), 128'(1));
    applyStimulus(b, 1'b1, 1'b0, '0, "bp_b");
    checkOutput("bp_a_drained", 128'(OUT_VALID), 128'(0));
    wait_valid(1'b0, "bp_b", n);
    checkOutput("bp_b_lat", 128'(n), 128'(7));
    checkOutput("bp_b_data", OUT_DATA, aes_ref(model_key, b, 1'b1));
    checkOutput("bp_b_mode", 128'(OUT_MODE), 128'(1));
    drain("bp_b");

    run_block(rand128(), 1'b0, 1'b0, '0, 4, 1'b1, 1'b0, "watchdog");
    run_block(rand128(), 1'b1, 1'b0, '0, 3, 1'b0, 1'b0, "after_wd");

    // DONE is still high from the previous command and stays high across START.
    core_keep_done = 1'b1;
    run_block(rand128(), 1'b0, 1'b0, '0, 5, 1'b0, 1'b0, "stale_done");
    core_keep_done = 1'b0;

    // Reset during WAIT abandons the command.
    core_latency = 6;
    applyStimulus(rand128(), 1'b0, 1'b1, rand128(), "rst_wait");
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_key = '0;
    #1;
    checkOutput("rst_wait_ready_after", 128'(IN_READY), 128'(1));
    checkOutput("rst_wait_idle", 128'(BUSY), 128'(0));
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (OUT_VALID) seen = 1'b1;
    end
    checkOutput("rst_wait_no_output", 128'(seen), 128'(0));

    // Reset during START drops the pulse in the same cycle.
    applyStimulus(rand128(), 1'b1, 1'b0, '0, "rst_start");
    RST = 1'b1;
    #1;
    checkOutput("rst_start_drop", 128'(CORE_START), 128'(0));
    @(negedge CLK);
    RST = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (OUT_VALID) seen = 1'b1;
    end
    checkOutput("rst_start_no_output", 128'(seen), 128'(0));

    run_block(rand128(), 1'b0, 1'b1, KEY1, 5, 1'b0, 1'b1, "key_in_wait");
    run_block(PT2, 1'b0, 1'b1, KEY2, 4, 1'b0, 1'b0, "key_change");

    for (int i = 0; i < 24; i++) begin
      run_block(rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                rand128(), $urandom_range(3, 9), 1'b0, 1'b0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
